// File: rtl/gpio_irq.sv
// GPIO controller: per-pin output value/enable, synchronised inputs, atomic
// set/clear, and rising/falling edge interrupts with write-1-to-clear status.
module gpio_irq #(
  parameter int IO_CH       = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  input  logic [IO_CH-1:0]  gpio_in,
  output logic [IO_CH-1:0]  gpio_out,
  output logic [IO_CH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] REG_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] REG_DIR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] REG_SET  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_CLR  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] REG_RISE = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] REG_FALL = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] REG_STAT = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] REG_OUT  = ADDR_W'(7);

  logic [IO_CH-1:0] sync_q [SYNC_STAGES];
  logic [IO_CH-1:0] prev_q;
  logic [IO_CH-1:0] rise_en_q, fall_en_q, stat_q;
  logic [IO_CH-1:0] sync, rise, fall;
  logic [IO_CH-1:0] wr_bits, out_d, oe_d, rise_en_d, fall_en_d, w1c, stat_d;
  logic [DATA_W-1:0] rd_mux;
  logic              access, wr_en;

  // Bits above IO_CH have no storage; the full bus is tapped so none dangle.
  logic [DATA_W-1:0] unused_wr_data;
  assign unused_wr_data = wr_data;

  assign access  = !cs_ && !as_;
  assign wr_en   = access && !rw;
  assign wr_bits = wr_data[IO_CH-1:0];

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q & rise_en_q;
  assign fall = ~sync & prev_q & fall_en_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      REG_DATA: rd_mux = DATA_W'(sync);
      REG_DIR:  rd_mux = DATA_W'(gpio_oe);
      REG_RISE: rd_mux = DATA_W'(rise_en_q);
      REG_FALL: rd_mux = DATA_W'(fall_en_q);
      REG_STAT: rd_mux = DATA_W'(stat_q);
      REG_OUT:  rd_mux = DATA_W'(gpio_out);
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    out_d     = gpio_out;
    oe_d      = gpio_oe;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr_en) begin
      unique case (addr)
        REG_DATA: out_d     = wr_bits;
        REG_DIR:  oe_d      = wr_bits;
        REG_SET:  out_d     = gpio_out | wr_bits;
        REG_CLR:  out_d     = gpio_out & ~wr_bits;
        REG_RISE: rise_en_d = wr_bits;
        REG_FALL: fall_en_d = wr_bits;
        REG_STAT: w1c       = wr_bits;
        default:  ;
      endcase
    end
    // A fresh edge outranks a simultaneous clear of the same bit.
    stat_d = (stat_q & ~w1c) | rise | fall;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the synchroniser array is reset too, so no phantom edge can be
      // seen against a cleared prev flop when reset releases.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q    <= '0;
      gpio_out  <= '0;
      gpio_oe   <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      irq       <= 1'b0;
      rdy_      <= 1'b1;
      rd_data   <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= sync;
      gpio_out  <= out_d;
      gpio_oe   <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      irq       <= |stat_d;
      rdy_      <= !access;
      rd_data   <= (access && rw) ? rd_mux : '0;
    end
  end

endmodule
